// File: rtl/fifo_uart_tx_pkg.sv
// Shared constants for the FIFO-fed UART transmitter: FSM state encoding
// and the default baud divisor.
package fifo_uart_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   // 50 MHz system clock at 115200 baud
   localparam int CLKS_PER_BIT_115200 = 434;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO-read / serial-line bundle between the FIFO stage, the transmitter
// and the TX pin.
interface fifo_uart_tx_if #(
   parameter int DATA_BITS = 8
);
   logic                 fifo_empty;
   logic [DATA_BITS-1:0] fifo_data;
   logic                 fifo_trig_read;
   logic                 tx;
   logic                 busy;

   modport master (
      output fifo_empty, fifo_data,
      input  fifo_trig_read, tx, busy
   );

   modport slave (
      input  fifo_empty, fifo_data,
      output fifo_trig_read, tx, busy
   );
endinterface

// File: rtl/fifo_uart_tx_baud_tick.sv
// Bit-period timer: one-cycle tick every CLKS_PER_BIT clocks, restartable
// through a synchronous clear.
module baud_tick #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick_o
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == CW'(CLKS_PER_BIT - 1));

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr || tick_o) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/fifo_uart_tx.sv
// Drains bytes from the communication FIFO and sends each as an 8N1-style
// frame; pulses the FIFO read trigger once per captured byte.
module fifo_uart_tx
   import fifo_uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int TRIG_CYCLES  = 2
) (
   input  logic           clk,
   input  logic           rst,
   fifo_uart_tx_if.slave  bus
);
   localparam int BW = (DATA_BITS > 1)   ? $clog2(DATA_BITS)   : 1;
   localparam int SW = (STOP_BITS > 1)   ? $clog2(STOP_BITS)   : 1;
   localparam int TW = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;

   tx_state_e            state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [SW-1:0]        stop_q, stop_d;
   logic [TW-1:0]        tcnt_q, tcnt_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 trig_q, trig_d;
   logic                 tick;
   logic                 baud_clr;

   // Restart the bit timer on every state entry and hold it while idle
   assign baud_clr = (state_d != state_q) || (state_q == IDLE);

   baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk    (clk),
      .rst    (rst),
      .clr    (baud_clr),
      .tick_o (tick)
   );

   // Outputs are registered, so next-state logic also computes next tx/busy/trig
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      tcnt_d  = tcnt_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      trig_d  = trig_q;

      if (trig_q) begin
         if (tcnt_q == TW'(TRIG_CYCLES - 1)) trig_d = 1'b0;
         else                                tcnt_d = tcnt_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (!bus.fifo_empty) begin
               shift_d = bus.fifo_data;
               state_d = START;
               busy_d  = 1'b1;
               trig_d  = 1'b1;
               tcnt_d  = '0;
               tx_d    = 1'b0;
            end
         end
         START: begin
            if (tick) begin
               state_d = DATA;
               bit_d   = '0;
               tx_d    = shift_q[0];
            end
         end
         DATA: begin
            if (tick) begin
               if (bit_q == BW'(DATA_BITS - 1)) begin
                  state_d = STOP;
                  stop_d  = '0;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = bit_q + 1'b1;
                  tx_d  = shift_q[bit_d];
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (stop_q == SW'(STOP_BITS - 1)) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  tx_d    = 1'b1;
               end else begin
                  stop_d = stop_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         bit_q   <= '0;
         stop_q  <= '0;
         tcnt_q  <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         trig_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         tcnt_q  <= tcnt_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         trig_q  <= trig_d;
      end
   end

   assign bus.tx             = tx_q;
   assign bus.busy           = busy_q;
   assign bus.fifo_trig_read = trig_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: a queue model of the FIFO feeds the transmitter, and a
// frame monitor rebuilds each expected waveform from the queued byte.
module tb_fifo_uart_tx;
   localparam int CPB   = 4;
   localparam int TRIG  = 2;
   localparam int FRAME = CPB * 10;

   typedef struct {
      logic [7:0] d;
      bit         abort;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst2 = 1'b1;
   always #5 clk = ~clk;

   fifo_uart_tx_if #(.DATA_BITS(8)) bus ();
   fifo_uart_tx_if #(.DATA_BITS(8)) bus2 ();

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .TRIG_CYCLES(TRIG)) dut (
      .clk (clk), .rst (rst), .bus (bus.slave));

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2), .TRIG_CYCLES(TRIG)) dut2 (
      .clk (clk), .rst (rst2), .bus (bus2.slave));

   exp_t       exp_q[$];
   logic [7:0] mfifo[$];
   logic [7:0] junk = 8'h00;
   int errors = 0, checks = 0;
   int trig_rises = 0, pushed = 0;
   bit trig_prev_m = 1'b0, trig_prev_c = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic push(input logic [7:0] d, input bit ab);
      exp_t e;
      e.d = d;
      e.abort = ab;
      mfifo.push_back(d);
      exp_q.push_back(e);
      pushed++;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || mfifo.size() != 0 || bus.busy !== 1'b0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      chk(name, 32'(n < 3000), 32'd1);
   endtask

   // Model FIFO: pops on each rising edge of the read trigger
   always @(posedge clk) begin
      #1;
      if (bus.fifo_trig_read === 1'b1 && !trig_prev_m && mfifo.size() > 0)
         void'(mfifo.pop_front());
      trig_prev_m = (bus.fifo_trig_read === 1'b1);
      bus.fifo_empty = (mfifo.size() == 0);
      bus.fifo_data  = (mfifo.size() > 0) ? mfifo[0] : junk;
   end

   always @(negedge clk) begin
      if (bus.fifo_trig_read === 1'b1 && !trig_prev_c) trig_rises++;
      trig_prev_c = (bus.fifo_trig_read === 1'b1);
   end

   // Frame monitor
   initial begin : mon
      logic       prev;
      exp_t       e;
      bit         ok_tx, ok_b, ok_t, aborted;
      logic [7:0] got;
      logic       etx;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (rst !== 1'b0 || bus.tx !== 1'b0 || prev !== 1'b1) begin
            prev = bus.tx;
         end else begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame: got start bit, expected idle");
               e.d = 8'h00;
               e.abort = 1'b0;
            end else begin
               e = exp_q.pop_front();
            end
            ok_tx = 1'b1; ok_b = 1'b1; ok_t = 1'b1; aborted = 1'b0; got = 8'h00;
            for (int c = 0; c < FRAME; c++) begin
               if (c > 0) @(negedge clk);
               if (rst === 1'b1) begin
                  aborted = 1'b1;
                  break;
               end
               if (c < CPB)          etx = 1'b0;
               else if (c < CPB * 9) etx = e.d[(c - CPB) / CPB];
               else                  etx = 1'b1;
               if (bus.tx !== etx)                          ok_tx = 1'b0;
               if (bus.busy !== 1'b1)                       ok_b  = 1'b0;
               if (bus.fifo_trig_read !== (c < TRIG))       ok_t  = 1'b0;
               if (c >= CPB && c < CPB * 9 && (c % CPB) == CPB / 2)
                  got[(c - CPB) / CPB] = bus.tx;
            end
            chk($sformatf("tx_wave_%02h", e.d), 32'(ok_tx), 32'd1);
            chk($sformatf("busy_frame_%02h", e.d), 32'(ok_b), 32'd1);
            chk($sformatf("trig_pulse_%02h", e.d), 32'(ok_t), 32'd1);
            if (aborted) begin
               @(negedge clk);
               chk("reset_tx_high", 32'(bus.tx), 32'd1);
               chk("reset_busy_low", 32'(bus.busy), 32'd0);
               chk("reset_trig_low", 32'(bus.fifo_trig_read), 32'd0);
            end else begin
               chk("decoded_byte", 32'(got), 32'(e.d));
               @(negedge clk);
               chk("idle_gap_tx", 32'(bus.tx), 32'd1);
               chk("idle_gap_busy", 32'(bus.busy), 32'd0);
            end
            prev = bus.tx;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, expected finish within time limit");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n, base, bad;
      logic       txs[60];
      logic       bs[60];
      logic [7:0] g2;
      int         blen, slen;

      bus2.fifo_empty = 1'b1;
      bus2.fifo_data  = 8'h00;

      // Reset with a byte already waiting
      rst = 1'b1;
      push(8'hA5, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("rst_tx", 32'(bus.tx), 32'd1);
         chk("rst_busy", 32'(bus.busy), 32'd0);
         chk("rst_trig", 32'(bus.fifo_trig_read), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("start_latency_tx", 32'(bus.tx), 32'd0);
      chk("start_latency_trig", 32'(bus.fifo_trig_read), 32'd1);
      wait_idle("single_byte_done");

      // Full FIFO drain
      base = trig_rises;
      @(posedge clk); #1;
      push(8'h01, 1'b0); push(8'h80, 1'b0); push(8'hFF, 1'b0); push(8'h00, 1'b0);
      wait_idle("four_bytes_done");
      chk("four_trig_edges", 32'(trig_rises - base), 32'd4);
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.tx !== 1'b1 || bus.busy !== 1'b0) bad++;
      end
      chk("empty_stays_idle", 32'(bad), 32'd0);

      // Data hold: head data changes mid-frame
      @(posedge clk); #1;
      push(8'hC3, 1'b0);
      n = 0;
      while (bus.busy !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
      chk("hold_start", 32'(n < 100), 32'd1);
      repeat (6) @(posedge clk);
      #1 junk = 8'h3C;
      wait_idle("hold_done");
      junk = 8'h00;

      // Randomized traffic, FIFO never above 4 entries
      for (int k = 0; k < 16; k++) begin
         @(posedge clk); #1;
         if (mfifo.size() < 4 && ($urandom % 3) != 0) push(8'($urandom_range(0, 255)), 1'b0);
         repeat ($urandom_range(0, 50)) @(posedge clk);
      end
      wait_idle("random_done");

      // Reset during bit 3 of 0x55, then 0x66 must go out intact
      @(posedge clk); #1;
      push(8'h55, 1'b1);
      push(8'h66, 1'b0);
      n = 0;
      while (bus.busy !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
      chk("abort_frame_start", 32'(n < 100), 32'd1);
      repeat (17) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      wait_idle("after_reset_done");
      chk("total_trig_edges", 32'(trig_rises), 32'(pushed));
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      // Two stop bits on the second instance
      @(posedge clk); #1 rst2 = 1'b0;
      @(posedge clk); #1;
      bus2.fifo_data  = 8'h0F;
      bus2.fifo_empty = 1'b0;
      @(posedge clk); #1;
      bus2.fifo_empty = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         txs[c] = bus2.tx;
         bs[c]  = bus2.busy;
      end
      blen = 0;
      while (blen < 60 && bs[blen] === 1'b1) blen++;
      chk("stop2_frame_len", 32'(blen), 32'd44);
      slen = 0;
      while (36 + slen < 60 && txs[36 + slen] === 1'b1 && bs[36 + slen] === 1'b1) slen++;
      chk("stop2_stop_len", 32'(slen), 32'd8);
      chk("stop2_start_bit", 32'({txs[0], txs[1], txs[2], txs[3]}), 32'd0);
      for (int i = 0; i < 8; i++) g2[i] = txs[CPB * (1 + i) + 2];
      chk("stop2_data", 32'(g2), 32'h0F);
      chk("stop2_idle_after", 32'(txs[44]), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
